// File: rtl/n64_cfg_bridge.sv
// n64_cfg_bridge
//   Turns N64 PI half-word accesses that land in the config window into
//   32-bit single-word requests for the cart configuration register block.
//   A write is assembled from two halves: the high half at offset[1]=0 is held,
//   and the low half at offset[1]=1 issues the request. A read at offset[1]=0
//   fetches the whole word and returns its high half. A read at offset[1]=1
//   returns the low half of the latched word without a new request.
//
//   Optional build macro: N64_CFG_BRIDGE_TIMEOUT_EN adds a wait counter that
//   abandons a request after TIMEOUT_CYCLES cycles without i_ack.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_n64_reset             synchronised N64 reset level (aborts transactions)
//   i_pi_read_op/write_op   1-cycle PI half-word op pulses
//   i_pi_address/wdata      PI byte address and write half-word
//   o_pi_hit                combinational: address is inside the window
//   o_pi_rdata              read half-word, valid while o_pi_busy is low
//   o_pi_busy               register-block transaction in flight
//   o_overrun, o_timeout    sticky error flags, cleared only by i_reset
//   o_select/read_rq/write_rq/address/data, i_ack/i_data
//                           register-block request/response interface
module n64_cfg_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h1FFF_0000,
    parameter int unsigned ADDR_BITS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_n64_reset,
    input  logic        i_pi_read_op,
    input  logic        i_pi_write_op,
    input  logic [31:0] i_pi_address,
    input  logic [15:0] i_pi_wdata,
    output logic        o_pi_hit,
    output logic [15:0] o_pi_rdata,
    output logic        o_pi_busy,
    output logic        o_overrun,
    output logic        o_timeout,
    output logic        o_select,
    output logic        o_read_rq,
    output logic        o_write_rq,
    output logic [31:0] o_address,
    output logic [31:0] o_data,
    input  logic        i_ack,
    input  logic [31:0] i_data
);

    localparam logic [31:0] WINDOW_BYTES = 32'(1) << ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_WRITE_WAIT = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic        select_q,   select_d;
    logic        read_rq_q,  read_rq_d;
    logic        write_rq_q, write_rq_d;
    logic [31:0] address_q,  address_d;
    logic [31:0] data_q,     data_d;
    logic [31:0] rd_word_q,  rd_word_d;
    logic [15:0] rdata_q,    rdata_d;
    logic        overrun_q,  overrun_d;

`ifdef N64_CFG_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Window decode: unsigned distance from the base, so addresses below wrap high.
    logic [31:0]          pi_delta;
    logic [ADDR_BITS-1:0] offset;
    logic [31:0]          word_addr;
    logic                 wr_hit;
    logic                 rd_hit;

    assign pi_delta  = i_pi_address - BASE_ADDR;
    assign o_pi_hit  = (pi_delta < WINDOW_BYTES);
    assign offset    = i_pi_address[ADDR_BITS-1:0];
    assign word_addr = 32'({offset[ADDR_BITS-1:2], 2'b00});
    assign wr_hit    = i_pi_write_op & o_pi_hit;
    assign rd_hit    = i_pi_read_op & o_pi_hit;

    // Next-state and output computation.
    always_comb begin
        state_d    = state_q;
        select_d   = select_q;
        read_rq_d  = 1'b0;
        write_rq_d = 1'b0;
        address_d  = address_q;
        data_d     = data_q;
        rd_word_d  = rd_word_q;
        rdata_d    = rdata_q;
        overrun_d  = overrun_q;
`ifdef N64_CFG_BRIDGE_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
`endif

        if (i_n64_reset) begin
            // Console reset: abandon any transaction and forget a pending high half.
            state_d        = ST_IDLE;
            select_d       = 1'b0;
            data_d[31:16]  = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_hit) begin
                        // A simultaneous read loses to the write.
                        if (rd_hit) begin
                            overrun_d = 1'b1;
                        end
                        if (!offset[1]) begin
                            data_d[31:16] = i_pi_wdata;
                        end else begin
                            data_d[15:0] = i_pi_wdata;
                            select_d     = 1'b1;
                            write_rq_d   = 1'b1;
                            address_d    = word_addr;
                            state_d      = ST_WRITE_WAIT;
`ifdef N64_CFG_BRIDGE_TIMEOUT_EN
                            cnt_d        = '0;
`endif
                        end
                    end else if (rd_hit) begin
                        if (!offset[1]) begin
                            select_d  = 1'b1;
                            read_rq_d = 1'b1;
                            address_d = word_addr;
                            state_d   = ST_READ_WAIT;
`ifdef N64_CFG_BRIDGE_TIMEOUT_EN
                            cnt_d     = '0;
`endif
                        end else begin
                            rdata_d = rd_word_q[15:0];
                        end
                    end
                end

                ST_READ_WAIT: begin
                    if (wr_hit || rd_hit) begin
                        overrun_d = 1'b1;
                    end
                    if (i_ack) begin
                        rd_word_d = i_data;
                        rdata_d   = i_data[31:16];
                        select_d  = 1'b0;
                        state_d   = ST_IDLE;
                    end
`ifdef N64_CFG_BRIDGE_TIMEOUT_EN
                    else if (cnt_q == CNT_LIMIT) begin
                        // No answer: hand back all-ones like an open bus.
                        rd_word_d = 32'hFFFF_FFFF;
                        rdata_d   = 16'hFFFF;
                        timeout_d = 1'b1;
                        select_d  = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end

                ST_WRITE_WAIT: begin
                    if (wr_hit || rd_hit) begin
                        overrun_d = 1'b1;
                    end
                    if (i_ack) begin
                        select_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
`ifdef N64_CFG_BRIDGE_TIMEOUT_EN
                    else if (cnt_q == CNT_LIMIT) begin
                        timeout_d = 1'b1;
                        select_d  = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end

                default: begin
                    select_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            select_q   <= 1'b0;
            read_rq_q  <= 1'b0;
            write_rq_q <= 1'b0;
            address_q  <= 32'h0;
            data_q     <= 32'h0;
            rd_word_q  <= 32'h0;
            rdata_q    <= 16'h0;
            overrun_q  <= 1'b0;
`ifdef N64_CFG_BRIDGE_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            select_q   <= select_d;
            read_rq_q  <= read_rq_d;
            write_rq_q <= write_rq_d;
            address_q  <= address_d;
            data_q     <= data_d;
            rd_word_q  <= rd_word_d;
            rdata_q    <= rdata_d;
            overrun_q  <= overrun_d;
`ifdef N64_CFG_BRIDGE_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign o_pi_busy  = (state_q != ST_IDLE);
    assign o_pi_rdata = rdata_q;
    assign o_overrun  = overrun_q;
    assign o_select   = select_q;
    assign o_read_rq  = read_rq_q;
    assign o_write_rq = write_rq_q;
    assign o_address  = address_q;
    assign o_data     = data_q;
`ifdef N64_CFG_BRIDGE_TIMEOUT_EN
    assign o_timeout  = timeout_q;
`else
    assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_n64_cfg_bridge.sv
// Testbench for n64_cfg_bridge: directed steps plus randomized half-word
// traffic, checked against a word-level model of the config register space.
module tb_n64_cfg_bridge;

    localparam logic [31:0] BASE   = 32'h1FFF_0000;
    localparam int unsigned TO_CYC = 8;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_n64_reset = 1'b0;
    logic        i_pi_read_op = 1'b0;
    logic        i_pi_write_op = 1'b0;
    logic [31:0] i_pi_address = 32'h0;
    logic [15:0] i_pi_wdata = 16'h0;
    logic        i_ack = 1'b0;
    logic [31:0] i_data = 32'h0;
    logic        o_pi_hit;
    logic [15:0] o_pi_rdata;
    logic        o_pi_busy;
    logic        o_overrun;
    logic        o_timeout;
    logic        o_select;
    logic        o_read_rq;
    logic        o_write_rq;
    logic [31:0] o_address;
    logic [31:0] o_data;

    always #5 i_clk = ~i_clk;

    n64_cfg_bridge #(
        .BASE_ADDR      (BASE),
        .ADDR_BITS      (4),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_n64_reset   (i_n64_reset),
        .i_pi_read_op  (i_pi_read_op),
        .i_pi_write_op (i_pi_write_op),
        .i_pi_address  (i_pi_address),
        .i_pi_wdata    (i_pi_wdata),
        .o_pi_hit      (o_pi_hit),
        .o_pi_rdata    (o_pi_rdata),
        .o_pi_busy     (o_pi_busy),
        .o_overrun     (o_overrun),
        .o_timeout     (o_timeout),
        .o_select      (o_select),
        .o_read_rq     (o_read_rq),
        .o_write_rq    (o_write_rq),
        .o_address     (o_address),
        .o_data        (o_data),
        .i_ack         (i_ack),
        .i_data        (i_data)
    );

    int checks = 0;
    int errors = 0;

    // Register-block stub: stores writes, answers requests after ack_delay cycles.
    int          n_wr = 0;
    int          n_rd = 0;
    bit          ack_en = 1'b1;
    int          ack_delay = 1;
    int          pend_cnt = 0;
    logic [1:0]  pend_idx = 2'd0;
    logic        stray_ack = 1'b0;
    logic [31:0] stray_data = 32'h0;
    logic [31:0] stub_mem [4] = '{32'h0, 32'h0000_00E5, 32'h0, 32'h0};

    always @(negedge i_clk) begin
        i_ack = stray_ack;
        if (stray_ack) i_data = stray_data;
        if (pend_cnt != 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                i_ack  = 1'b1;
                i_data = stub_mem[pend_idx];
            end
        end
        if (o_write_rq === 1'b1) begin
            n_wr++;
            stub_mem[o_address[3:2]] = o_data;
            if (ack_en) begin
                pend_cnt = ack_delay;
                pend_idx = o_address[3:2];
            end
        end
        if (o_read_rq === 1'b1) begin
            n_rd++;
            if (ack_en) begin
                pend_cnt = ack_delay;
                pend_idx = o_address[3:2];
            end
        end
    end

    // Reference model: contents of the four config words and the PI-visible latches.
    logic [31:0] ref_mem [4] = '{32'h0, 32'h0000_00E5, 32'h0, 32'h0};
    logic [15:0] ref_hi    = 16'h0;
    logic [31:0] ref_latch = 32'h0;
    logic [15:0] ref_rdata = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pi_op(input logic rd, input logic wr, input logic [31:0] a, input logic [15:0] d);
        i_pi_read_op  = rd;
        i_pi_write_op = wr;
        i_pi_address  = a;
        i_pi_wdata    = d;
        tick();
        i_pi_read_op  = 1'b0;
        i_pi_write_op = 1'b0;
    endtask

    // Count cycles from now until o_pi_busy drops, bounded.
    task automatic wait_idle(input string tag, output int cyc);
        cyc = 0;
        while (o_pi_busy !== 1'b0 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk(tag, 32'(o_pi_busy), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int wr0;
        int rd0;
        logic [31:0] w;
        logic [31:0] a;
        int k;
        int k2;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy",     32'(o_pi_busy),  32'h0);
        chk("rst_select",   32'(o_select),   32'h0);
        chk("rst_read_rq",  32'(o_read_rq),  32'h0);
        chk("rst_write_rq", 32'(o_write_rq), 32'h0);
        chk("rst_address",  o_address,       32'h0);
        chk("rst_data",     o_data,          32'h0);
        chk("rst_rdata",    32'(o_pi_rdata), 32'h0);
        chk("rst_overrun",  32'(o_overrun),  32'h0);
        chk("rst_timeout",  32'(o_timeout),  32'h0);
        i_reset = 1'b0;
        tick();

        // Two-half write issues exactly one request, busy for two cycles
        wr0 = n_wr;
        pi_op(1'b0, 1'b1, BASE, 16'h0000);
        ref_hi = 16'h0000;
        chk("t1_hi_no_req", 32'(o_write_rq), 32'h0);
        pi_op(1'b0, 1'b1, BASE + 32'h2, 16'h0002);
        chk("t1_write_rq", 32'(o_write_rq), 32'h1);
        chk("t1_select",   32'(o_select),   32'h1);
        chk("t1_address",  o_address,       32'h0);
        chk("t1_data",     o_data,          {ref_hi, 16'h0002});
        ref_mem[0] = {ref_hi, 16'h0002};
        wait_idle("t1_idle", cyc);
        chk("t1_busy_cycles", 32'(cyc), 32'd2);
        chk("t1_select_low",  32'(o_select), 32'h0);
        chk("t1_one_wr_rq",   32'(n_wr - wr0), 32'd1);

        // Read high half fetches the word; low half served from the latch
        rd0 = n_rd;
        pi_op(1'b1, 1'b0, BASE + 32'h4, 16'h0);
        chk("t2_read_rq", 32'(o_read_rq), 32'h1);
        chk("t2_address", o_address,      32'h4);
        wait_idle("t2_idle", cyc);
        ref_latch = ref_mem[1];
        ref_rdata = ref_latch[31:16];
        chk("t2_rdata_hi", 32'(o_pi_rdata), 32'(ref_rdata));
        pi_op(1'b1, 1'b0, BASE + 32'h6, 16'h0);
        ref_rdata = ref_latch[15:0];
        chk("t2_rdata_lo", 32'(o_pi_rdata), 32'h0000_00E5);
        chk("t2_lo_busy",  32'(o_pi_busy),  32'h0);
        tick();
        chk("t2_one_rd_rq", 32'(n_rd - rd0), 32'd1);

        // Out-of-window ops are ignored
        wr0 = n_wr;
        pi_op(1'b0, 1'b1, BASE, 16'hAAAA);
        ref_hi = 16'hAAAA;
        i_pi_address = BASE + 32'h10;
        #1;
        chk("t3_hit_above", 32'(o_pi_hit), 32'h0);
        pi_op(1'b0, 1'b1, BASE + 32'h10, 16'h5555);
        chk("t3_above_busy", 32'(o_pi_busy), 32'h0);
        i_pi_address = 32'h1FFE_FFFE;
        #1;
        chk("t3_hit_below", 32'(o_pi_hit), 32'h0);
        pi_op(1'b0, 1'b1, 32'h1FFE_FFFE, 16'h5555);
        chk("t3_below_busy", 32'(o_pi_busy), 32'h0);
        chk("t3_hi_kept",    32'(o_data[31:16]), 32'(ref_hi));
        i_pi_address = BASE + 32'hE;
        #1;
        chk("t3_hit_top", 32'(o_pi_hit), 32'h1);
        tick();
        chk("t3_no_wr_rq", 32'(n_wr - wr0), 32'd0);

        // Op during WRITE_WAIT is dropped and flagged
        ack_delay = 2;
        wr0 = n_wr;
        pi_op(1'b0, 1'b1, BASE, 16'h1357);
        ref_hi = 16'h1357;
        pi_op(1'b0, 1'b1, BASE + 32'h2, 16'h9BDF);
        chk("t4_busy", 32'(o_pi_busy), 32'h1);
        pi_op(1'b0, 1'b1, BASE + 32'h6, 16'hFFFF);
        chk("t4_overrun", 32'(o_overrun), 32'h1);
        chk("t4_data",    o_data,         32'h1357_9BDF);
        ref_mem[0] = 32'h1357_9BDF;
        wait_idle("t4_idle", cyc);
        tick();
        chk("t4_one_wr_rq", 32'(n_wr - wr0), 32'd1);

        // Randomized traffic against the word model
        for (int n = 0; n < 40; n++) begin
            ack_delay = int'($urandom_range(1, 4));
            k  = int'($urandom_range(0, 3));
            k2 = int'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: begin
                    w = $urandom;
                    pi_op(1'b0, 1'b1, BASE + 32'(4 * k), w[31:16]);
                    ref_hi = w[31:16];
                    chk("rnd_hi_idle", 32'(o_pi_busy), 32'h0);
                    pi_op(1'b0, 1'b1, BASE + 32'(4 * k2) + 32'h2, w[15:0]);
                    chk("rnd_wr_rq",   32'(o_write_rq), 32'h1);
                    chk("rnd_wr_addr", o_address, 32'(4 * k2));
                    chk("rnd_wr_data", o_data, {ref_hi, w[15:0]});
                    ref_mem[k2] = {ref_hi, w[15:0]};
                    wait_idle("rnd_wr_idle", cyc);
                end
                1: begin
                    pi_op(1'b1, 1'b0, BASE + 32'(4 * k), 16'h0);
                    chk("rnd_rd_rq",   32'(o_read_rq), 32'h1);
                    chk("rnd_rd_addr", o_address, 32'(4 * k));
                    wait_idle("rnd_rd_idle", cyc);
                    ref_latch = ref_mem[k];
                    ref_rdata = ref_latch[31:16];
                    chk("rnd_rdata_hi", 32'(o_pi_rdata), 32'(ref_rdata));
                    pi_op(1'b1, 1'b0, BASE + 32'(4 * k2) + 32'h2, 16'h0);
                    ref_rdata = ref_latch[15:0];
                    chk("rnd_rdata_lo", 32'(o_pi_rdata), 32'(ref_rdata));
                end
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        a = BASE + 32'h10 + 32'($urandom_range(0, 65535));
                    else
                        a = BASE - 32'h1 - 32'($urandom_range(0, 65535));
                    i_pi_address = a;
                    #1;
                    chk("rnd_miss_hit", 32'(o_pi_hit), 32'h0);
                    pi_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
                    chk("rnd_miss_busy",  32'(o_pi_busy), 32'h0);
                    chk("rnd_miss_rdata", 32'(o_pi_rdata), 32'(ref_rdata));
                end
            endcase
        end

        // N64 reset aborts READ_WAIT; a late ack is ignored
        ack_en = 1'b0;
        pi_op(1'b1, 1'b0, BASE + 32'h4, 16'h0);
        tick();
        chk("t6_wait_busy",   32'(o_pi_busy), 32'h1);
        chk("t6_wait_select", 32'(o_select),  32'h1);
        i_n64_reset = 1'b1;
        tick();
        i_n64_reset = 1'b0;
        chk("t6_abort_busy",   32'(o_pi_busy), 32'h0);
        chk("t6_abort_select", 32'(o_select),  32'h0);
        stray_data = 32'hDEAD_BEEF;
        stray_ack  = 1'b1;
        tick();
        tick();
        stray_ack  = 1'b0;
        chk("t6_stray_busy",  32'(o_pi_busy),  32'h0);
        chk("t6_stray_rdata", 32'(o_pi_rdata), 32'(ref_rdata));
        pi_op(1'b1, 1'b0, BASE + 32'h6, 16'h0);
        ref_rdata = ref_latch[15:0];
        chk("t6_latch_kept",   32'(o_pi_rdata), 32'(ref_rdata));
        chk("t6_overrun_kept", 32'(o_overrun),  32'h1);

        // N64 reset clears a pending high half
        ack_en = 1'b1;
        ack_delay = 1;
        pi_op(1'b0, 1'b1, BASE, 16'h1111);
        i_n64_reset = 1'b1;
        tick();
        i_n64_reset = 1'b0;
        ref_hi = 16'h0000;
        pi_op(1'b0, 1'b1, BASE + 32'h2, 16'h2222);
        chk("t6_hi_cleared", o_data, {ref_hi, 16'h2222});
        ref_mem[0] = {ref_hi, 16'h2222};
        wait_idle("t6_wr_idle", cyc);

        // No ack: timeout build gives up, default build waits
        ack_en = 1'b0;
`ifdef N64_CFG_BRIDGE_TIMEOUT_EN
        pi_op(1'b1, 1'b0, BASE + 32'h8, 16'h0);
        wait_idle("t5_idle", cyc);
        checks++;
        assert (cyc >= int'(TO_CYC) && cyc <= int'(TO_CYC) + 2) else begin
            errors++;
            $error("FAIL t5_busy_cycles observed=%0d expected=%0d..%0d", cyc, TO_CYC, TO_CYC + 2);
        end
        ref_latch = 32'hFFFF_FFFF;
        ref_rdata = 16'hFFFF;
        chk("t5_timeout", 32'(o_timeout),  32'h1);
        chk("t5_rdata",   32'(o_pi_rdata), 32'(ref_rdata));
        pi_op(1'b1, 1'b0, BASE + 32'hA, 16'h0);
        chk("t5_rdata_lo", 32'(o_pi_rdata), 32'h0000_FFFF);
`else
        pi_op(1'b1, 1'b0, BASE + 32'h8, 16'h0);
        repeat (20) tick();
        chk("t5_held_busy", 32'(o_pi_busy), 32'h1);
        chk("t5_no_timeout", 32'(o_timeout), 32'h0);
        i_n64_reset = 1'b1;
        tick();
        i_n64_reset = 1'b0;
        chk("t5_released", 32'(o_pi_busy), 32'h0);
`endif

        // Asynchronous reset in the middle of WRITE_WAIT
        pi_op(1'b0, 1'b1, BASE + 32'h2, 16'h3333);
        ref_mem[0] = {ref_hi, 16'h3333};
        tick();
        chk("t7_busy", 32'(o_pi_busy), 32'h1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("t7_busy0",     32'(o_pi_busy),  32'h0);
        chk("t7_select0",   32'(o_select),   32'h0);
        chk("t7_write_rq0", 32'(o_write_rq), 32'h0);
        chk("t7_address0",  o_address,       32'h0);
        chk("t7_data0",     o_data,          32'h0);
        chk("t7_rdata0",    32'(o_pi_rdata), 32'h0);
        chk("t7_overrun0",  32'(o_overrun),  32'h0);
        chk("t7_timeout0",  32'(o_timeout),  32'h0);
        tick();
        i_reset = 1'b0;
        ref_hi = 16'h0;
        ref_latch = 32'h0;
        ref_rdata = 16'h0;
        tick();

        // Read and write together: write wins, read is an overrun
        ack_en = 1'b1;
        rd0 = n_rd;
        pi_op(1'b1, 1'b1, BASE, 16'h7777);
        ref_hi = 16'h7777;
        chk("t8_busy",    32'(o_pi_busy), 32'h0);
        chk("t8_read_rq", 32'(o_read_rq), 32'h0);
        chk("t8_overrun", 32'(o_overrun), 32'h1);
        chk("t8_hi",      o_data,         {ref_hi, 16'h0000});
        tick();
        chk("t8_no_rd_rq", 32'(n_rd - rd0), 32'd0);
        pi_op(1'b0, 1'b1, BASE + 32'h2, 16'h4444);
        ref_mem[0] = {ref_hi, 16'h4444};
        wait_idle("t8_wr_idle", cyc);
        pi_op(1'b1, 1'b0, BASE, 16'h0);
        wait_idle("t8_rd_idle", cyc);
        ref_latch = ref_mem[0];
        chk("t8_rdata_hi", 32'(o_pi_rdata), 32'(ref_latch[31:16]));
        pi_op(1'b1, 1'b0, BASE + 32'h2, 16'h0);
        chk("t8_rdata_lo", 32'(o_pi_rdata), 32'(ref_latch[15:0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
